// File: rtl/nvdla_sdp_e_rd_rsp_unpack.sv
// Unpacks 2-half CVIF read-response packets into a stream of HALF_DW-bit beats.
// A single registered entry holds the packet; only halves flagged in the mask are emitted, lower half first.
module nvdla_sdp_e_rd_rsp_unpack #(
  parameter int HALF_DW = 256
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   cvif2sdp_e_rd_rsp_valid,
  input  logic [2*HALF_DW+1:0]   cvif2sdp_e_rd_rsp_pd,
  output logic                   cvif2sdp_e_rd_rsp_ready,
  output logic                   dma_rd_rsp_vld,
  output logic [HALF_DW-1:0]     dma_rd_rsp_pd,
  output logic                   dma_rd_rsp_last,
  input  logic                   dma_rd_rsp_rdy,
  output logic                   mask_err
);

  logic                 hold_vld;
  logic [1:0]           hold_mask;
  logic [2*HALF_DW-1:0] hold_data;

  logic       in_acc;
  logic       out_acc;
  logic       in_load;
  logic [1:0] in_mask;

  assign in_mask = cvif2sdp_e_rd_rsp_pd[2*HALF_DW+1:2*HALF_DW];

  assign dma_rd_rsp_vld  = hold_vld;
  assign dma_rd_rsp_last = hold_vld && (hold_mask != 2'b11);
  assign dma_rd_rsp_pd   = hold_mask[0] ? hold_data[HALF_DW-1:0]
                                        : hold_data[2*HALF_DW-1:HALF_DW];

  // Ready depends only on holding state and downstream ready, so a new packet
  // can slide in behind the final beat without a bubble.
  assign cvif2sdp_e_rd_rsp_ready = !hold_vld || (dma_rd_rsp_rdy && dma_rd_rsp_last);

  assign in_acc  = cvif2sdp_e_rd_rsp_valid && cvif2sdp_e_rd_rsp_ready;
  assign out_acc = dma_rd_rsp_vld && dma_rd_rsp_rdy;
  assign in_load = in_acc && (in_mask != 2'b00);

  // Holding-entry control
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      hold_vld  <= 1'b0;
      hold_mask <= 2'b00;
      mask_err  <= 1'b0;
    end else begin
      if (in_load) begin
        hold_vld  <= 1'b1;
        hold_mask <= in_mask;
      end else if (out_acc && dma_rd_rsp_last) begin
        hold_vld  <= 1'b0;
      end else if (out_acc && (hold_mask == 2'b11)) begin
        hold_mask <= 2'b10;
      end
      if (in_acc && (in_mask == 2'b00)) begin
        mask_err <= 1'b1;
      end
    end
  end

  // Packet payload, qualified by hold_vld/hold_mask
  always_ff @(posedge nvdla_core_clk) begin
    if (in_load) begin
      hold_data <= cvif2sdp_e_rd_rsp_pd[2*HALF_DW-1:0];
    end
  end

endmodule

// File: tb/tb_nvdla_sdp_e_rd_rsp_unpack.sv
// Bench for nvdla_sdp_e_rd_rsp_unpack: directed vector table, async-reset sequence,
// and random traffic against a beat-queue reference model.
module tb_nvdla_sdp_e_rd_rsp_unpack;

  localparam int HW = 32;

  logic              clk;
  logic              rstn;
  logic              in_valid;
  logic [2*HW+1:0]   in_pd;
  logic              in_ready;
  logic              out_vld;
  logic [HW-1:0]     out_pd;
  logic              out_last;
  logic              out_rdy;
  logic              err;

  int n_cmp;
  int n_fail;

  nvdla_sdp_e_rd_rsp_unpack #(.HALF_DW(HW)) dut (
    .nvdla_core_clk          (clk),
    .nvdla_core_rstn         (rstn),
    .cvif2sdp_e_rd_rsp_valid (in_valid),
    .cvif2sdp_e_rd_rsp_pd    (in_pd),
    .cvif2sdp_e_rd_rsp_ready (in_ready),
    .dma_rd_rsp_vld          (out_vld),
    .dma_rd_rsp_pd           (out_pd),
    .dma_rd_rsp_last         (out_last),
    .dma_rd_rsp_rdy          (out_rdy),
    .mask_err                (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [1:0]    m;
    logic [HW-1:0] h0;
    logic [HW-1:0] h1;
    logic          rdy;
    logic          e_rdy;
    logic          e_vld;
    logic [HW-1:0] e_pd;
    logic          e_last;
    logic          e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [1:0] m, input logic [HW-1:0] h0,
                     input logic [HW-1:0] h1, input logic rdy, input logic e_rdy,
                     input logic e_vld, input logic [HW-1:0] e_pd, input logic e_last,
                     input logic e_err);
    vec_t t;
    t.v = v; t.m = m; t.h0 = h0; t.h1 = h1; t.rdy = rdy;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_pd = e_pd; t.e_last = e_last; t.e_err = e_err;
    tbl.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [HW-1:0] h0,
                       input logic [HW-1:0] h1, input logic rdy);
    in_valid = v;
    in_pd    = {m, h1, h0};
    out_rdy  = rdy;
  endtask

  // Reference model: the beats still owed by the held packet, oldest first.
  logic [HW-1:0] q_pd[$];
  logic          q_last[$];
  logic          m_err;

  initial begin
    logic          v, rdy, e_ready;
    logic [1:0]    m;
    logic [HW-1:0] h0, h1;

    n_cmp = 0; n_fail = 0;
    rstn = 1'b0;
    drive(1'b0, 2'b00, '0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_vld",   out_vld,  0);
    chk("rst_last",  out_last, 0);
    chk("rst_err",   err,      0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    //   v  m      h0            h1            rdy  e_rdy e_vld e_pd          e_last e_err
    add(1, 2'b01, 32'hA5A5A5A5, 32'h0,        1,   1,    0,    32'h0,        0,     0);
    add(1, 2'b01, 32'h11,       32'h22,       1,   1,    1,    32'hA5A5A5A5, 1,     0);
    add(1, 2'b10, 32'h33,       32'h44,       1,   1,    1,    32'h11,       1,     0);
    add(1, 2'b01, 32'h55,       32'h66,       1,   1,    1,    32'h44,       1,     0);
    add(1, 2'b11, 32'h1,        32'h2,        1,   1,    1,    32'h55,       1,     0);
    add(0, 2'b00, 32'h0,        32'h0,        1,   0,    1,    32'h1,        0,     0);
    add(1, 2'b11, 32'h7,        32'h8,        1,   1,    1,    32'h2,        1,     0);
    for (int i = 0; i < 5; i++)
      add(1, 2'b01, 32'hEE,     32'hEE,       0,   0,    1,    32'h7,        0,     0);
    add(1, 2'b01, 32'hEE,       32'hEE,       1,   0,    1,    32'h7,        0,     0);
    add(0, 2'b00, 32'h0,        32'h0,        0,   0,    1,    32'h8,        1,     0);
    add(0, 2'b00, 32'h0,        32'h0,        1,   1,    1,    32'h8,        1,     0);
    add(1, 2'b00, 32'h9,        32'h9,        1,   1,    0,    32'h0,        0,     0);
    add(1, 2'b01, 32'hBB,       32'h0,        1,   1,    0,    32'h0,        0,     1);
    add(0, 2'b00, 32'h0,        32'h0,        1,   1,    1,    32'hBB,       1,     1);
    add(0, 2'b00, 32'h0,        32'h0,        1,   1,    0,    32'h0,        0,     1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].m, tbl[i].h0, tbl[i].h1, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_vld", i),   out_vld,  tbl[i].e_vld);
      chk($sformatf("vec%0d_last", i),  out_last, tbl[i].e_last);
      chk($sformatf("vec%0d_err", i),   err,      tbl[i].e_err);
      if (tbl[i].e_vld) chk($sformatf("vec%0d_pd", i), out_pd, tbl[i].e_pd);
      @(posedge clk);
      #1;
    end

    // Reset landing between the two beats of a full packet.
    drive(1'b1, 2'b11, 32'hC, 32'hD, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 2'b00, '0, '0, 1'b1);
    @(negedge clk);
    chk("mid_pd0",   out_pd,   32'hC);
    chk("mid_last0", out_last, 0);
    @(posedge clk);
    #1;
    chk("mid_pd1",   out_pd,   32'hD);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_vld",   out_vld,  0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_err",   err,      0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_vld", out_vld, 0);
    end
    @(posedge clk);
    #1;

    // Random traffic against the beat-queue model.
    m_err = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 7);
      m   = ($urandom_range(0, 19) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      h0  = $urandom;
      h1  = $urandom;
      drive(v, m, h0, h1, rdy);
      e_ready = (q_pd.size() == 0) || (q_pd.size() == 1 && rdy);
      @(negedge clk);
      chk("rnd_ready", in_ready, e_ready);
      chk("rnd_vld",   out_vld,  q_pd.size() != 0);
      chk("rnd_err",   err,      m_err);
      if (q_pd.size() != 0) begin
        chk("rnd_pd",   out_pd,   q_pd[0]);
        chk("rnd_last", out_last, q_last[0]);
      end
      @(posedge clk);
      if (q_pd.size() != 0 && rdy) begin
        void'(q_pd.pop_front());
        void'(q_last.pop_front());
      end
      if (v && e_ready) begin
        if (m == 2'b00) m_err = 1'b1;
        if (m[0]) begin q_pd.push_back(h0); q_last.push_back(!m[1]); end
        if (m[1]) begin q_pd.push_back(h1); q_last.push_back(1'b1); end
      end
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
